rf_alu_sequencer: RTL
=====================

Name: rf_alu_sequencer

Overview:
Micro-sequencer that runs a short program of register-to-register ALU operations against the existing register file and ALU datapath. Each step fetches a 16-bit instruction from an external program table, reads two source registers, drives the ALU, and writes the result back. It replaces hand-sequenced FSM control for logical and arithmetic test programs. It also latches the last written value for the seven-segment display drivers.

Parameters:
DATA_W, 16, register/ALU data width
PROG_LEN, 16, number of program steps; must be a power of 2, at most 2**PC_W
PC_W, 4, program counter / instr_addr width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin program at step 0; sampled only in IDLE
instr_addr  out  PC_W  program table address (= pc)
instr_data  in  16  instruction {op[15:12], dst[11:8], srcA[7:4], srcB[3:0]}; combinational from instr_addr
rf_addr_a  out  4  regfile read port A address
rf_addr_b  out  4  regfile read port B address
rf_data_a  in  DATA_W  regfile read data A (combinational read)
rf_data_b  in  DATA_W  regfile read data B
alu_op  out  4  ALU opcode (op field, passed through uninterpreted)
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_result  in  DATA_W  ALU result (combinational)
rf_wr_en  out  1  regfile write enable
rf_wr_addr  out  4  regfile write address
rf_wr_data  out  DATA_W  regfile write data
busy  out  1  high in FETCH/READ/EXEC/WRITE
done  out  1  one-cycle pulse at program end
last_result  out  DATA_W  last value written to regfile, for display

Behaviour:
- Internal registers: state, pc, ir (16b), opa, opb, res, last_result.
- Reset: state=IDLE; pc, ir, opa, opb, res, last_result = 0. All outputs 0.
- rf_wr_en = (state==WRITE) & !reset. The gating is combinational, so no write lands on a reset edge.
- IDLE: busy=0. If start=1, then pc<=0 and state goes to FETCH.
- FETCH: instr_addr=pc; ir<=instr_data.
  - If instr_data[15:12]==4'hF (HALT), go to DONE with no write.
  - Otherwise go to READ.
- READ: rf_addr_a=ir.srcA, rf_addr_b=ir.srcB; opa<=rf_data_a, opb<=rf_data_b; go to EXEC.
- EXEC: alu_a=opa, alu_b=opb, alu_op=ir.op; res<=alu_result; go to WRITE.
- WRITE: rf_wr_addr=ir.dst, rf_wr_data=res; last_result<=res.
  - If pc==PROG_LEN-1, go to DONE.
  - Otherwise pc<=pc+1 and go to FETCH.
- DONE: done=1 for exactly one cycle, busy=0; go to IDLE. start is ignored in DONE.
- Address/operand outputs hold their registered source values in all states (no glitch-to-zero). rf_wr_en is high only in WRITE.
- Latency: 4 cycles per instruction, ending in WRITE.
  - N instructions with no HALT: done appears 4N+1 cycles after the start edge.
  - With a HALT: 1 cycle for the HALT fetch, then DONE.
- Read-after-write: the write at the end of WRITE is visible to the next instruction's READ. No forwarding is needed.
- start while busy: ignored. The pc never wraps mid-program; it is re-zeroed on the next start.
- Reset mid-operation: the next state is IDLE, and any in-flight write is suppressed.

Optional Feature:
Macro SEQ_STEP_EN.
- Defined: adds input port step (1 bit) and state PAUSE.
  - WRITE goes to PAUSE instead of FETCH; pc increments on leaving WRITE as usual.
  - PAUSE holds with busy=1 until step=1, then goes to FETCH. A program end still goes WRITE→DONE.
  - reset in PAUSE returns to IDLE.
- Undefined: no step port, no PAUSE state; continuous execution as above.

Test Plan:
- Reset: assert reset 2 cycles → busy=0, done=0, rf_wr_en=0, last_result=0, instr_addr=0.
- Bench preloads r1=0x00F0, r2=0x0F0F; bench ALU op 2 = OR; program {0x2312, 0xF000}; pulse start at edge E0 →
  - rf_wr_en high only in cycle 4, addr 3, data 0x0FFF;
  - done pulse in cycle 6; busy high cycles 1–5;
  - last_result=0x0FFF.
- Full program, 16 non-HALT instructions, no HALT → exactly 16 writes; done 65 cycles after start; instr_addr seen 0..15 in order.
- RAW: step0 = OR r3=r1|r2, step1 = op 1 (AND) r4=r3&r1 → r4=0x00F0, showing step1 read the new r3.
- Reset asserted in the WRITE cycle of step0 → no regfile write, IDLE next cycle, last_result=0.
- start held high across the whole run → exactly one program execution and one done pulse.
  - With SEQ_STEP_EN: no FETCH occurs after WRITE until a step pulse; each step pulse advances exactly one instruction.

Source files
------------

// File: rtl/rf_alu_sequencer.sv
// Micro-sequencer: fetches 16-bit register-to-register ALU instructions, reads operands,
// drives the ALU and writes back. Optional single-step PAUSE state under macro SEQ_STEP_EN.
module rf_alu_sequencer #(
   parameter int DATA_W   = 16,
   parameter int PROG_LEN = 16,
   parameter int PC_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef SEQ_STEP_EN
   input  logic              step,
`endif
   output logic [PC_W-1:0]   instr_addr,
   input  logic [15:0]       instr_data,
   output logic [3:0]        rf_addr_a,
   output logic [3:0]        rf_addr_b,
   input  logic [DATA_W-1:0] rf_data_a,
   input  logic [DATA_W-1:0] rf_data_b,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rf_wr_en,
   output logic [3:0]        rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] last_result
);

`ifdef SEQ_STEP_EN
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_READ, S_EXEC, S_WRITE, S_DONE, S_PAUSE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_READ, S_EXEC, S_WRITE, S_DONE
   } state_t;
`endif

   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);
   localparam logic [3:0]      OP_HALT = 4'hF;

   state_t              state;
   logic [PC_W-1:0]     pc;
   logic [15:0]         ir;
   logic [DATA_W-1:0]   opa;
   logic [DATA_W-1:0]   opb;
   logic [DATA_W-1:0]   res;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= '0;
         ir          <= '0;
         opa         <= '0;
         opb         <= '0;
         res         <= '0;
         last_result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc    <= '0;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               ir    <= instr_data;
               state <= (instr_data[15:12] == OP_HALT) ? S_DONE : S_READ;
            end
            S_READ: begin
               opa   <= rf_data_a;
               opb   <= rf_data_b;
               state <= S_EXEC;
            end
            S_EXEC: begin
               res   <= alu_result;
               state <= S_WRITE;
            end
            S_WRITE: begin
               last_result <= res;
               if (pc == PC_LAST) begin
                  state <= S_DONE;
               end else begin
                  pc <= pc + 1'b1;
`ifdef SEQ_STEP_EN
                  state <= S_PAUSE;
`else
                  state <= S_FETCH;
`endif
               end
            end
`ifdef SEQ_STEP_EN
            S_PAUSE: begin
               if (step) state <= S_FETCH;
            end
`endif
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Datapath outputs come straight from registers so they never glitch between states.
   assign instr_addr = pc;
   assign rf_addr_a  = ir[7:4];
   assign rf_addr_b  = ir[3:0];
   assign alu_op     = ir[15:12];
   assign alu_a      = opa;
   assign alu_b      = opb;
   assign rf_wr_addr = ir[11:8];
   assign rf_wr_data = res;

   // Reset gating keeps a write from landing on the same edge that aborts the program.
   assign rf_wr_en = (state == S_WRITE) && !reset;
   assign done     = (state == S_DONE);
`ifdef SEQ_STEP_EN
   assign busy = (state == S_FETCH) || (state == S_READ) || (state == S_EXEC) ||
                 (state == S_WRITE) || (state == S_PAUSE);
`else
   assign busy = (state == S_FETCH) || (state == S_READ) || (state == S_EXEC) ||
                 (state == S_WRITE);
`endif

endmodule
